// File: rtl/cmd_frame_aligner_pkg.sv
// Shared types and constants for the command-channel frame aligner.
// Holds the sync word default, frame width and aligner state encoding.
package rd53b_cmd_pkg;

    localparam int unsigned FRAME_W = 16;

    localparam logic [FRAME_W-1:0] SYNC_DEFAULT = 16'h817E;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

endpackage

// File: rtl/cmd_frame_aligner_if.sv
// Bundle between the upstream shift register / downstream frame consumer
// and the aligner: sliding window in, aligned frames and status out.
interface cmd_frame_aligner_if;
    import rd53b_cmd_pkg::*;

    logic [FRAME_W-1:0] data_i;
    logic [3:0]         shift_count_i;
    logic [FRAME_W-1:0] frame_o;
    logic               frame_valid_o;
    logic               locked_o;
    logic [3:0]         phase_o;
    logic [7:0]         unlock_count_o;
    logic [7:0]         sync_err_count_o;

    modport master (
        output data_i,
        output shift_count_i,
        input  frame_o,
        input  frame_valid_o,
        input  locked_o,
        input  phase_o,
        input  unlock_count_o,
        input  sync_err_count_o
    );

    modport slave (
        input  data_i,
        input  shift_count_i,
        output frame_o,
        output frame_valid_o,
        output locked_o,
        output phase_o,
        output unlock_count_o,
        output sync_err_count_o
    );

endinterface

// File: rtl/cmd_frame_aligner_sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
// Async reset and a synchronous clear both return it to zero.
module sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count
);

    // Count enabled events, holding at full scale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'h00;
        end else if (clear) begin
            count <= 8'h00;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/cmd_frame_aligner.sv
// Hunts for the sync word in the sliding window, locks onto its bit phase
// and emits aligned non-sync frames. Optional misaligned-sync counter is
// built when CMD_FRAME_ALIGNER_SYNCERR_EN is defined.
module cmd_frame_aligner
    import rd53b_cmd_pkg::*;
#(
    parameter logic [FRAME_W-1:0] SYNC_PATTERN = SYNC_DEFAULT,
    parameter int unsigned        LOCK_COUNT   = 4,
    parameter int unsigned        MAX_GAP      = 64
) (
    input  logic                clk,
    input  logic                reset,
    cmd_frame_aligner_if.slave  bus
);

    localparam logic [3:0] LC = LOCK_COUNT[3:0];
    localparam logic [7:0] MG = MAX_GAP[7:0];

    // A single sync is enough to lock when LOCK_COUNT is 1.
    localparam align_state_t ACQ_NEXT =
        (LOCK_COUNT == 1) ? LOCKED : VERIFY;

    align_state_t       state;
    logic [3:0]         phase_q;
    logic [3:0]         sync_cnt;
    logic [7:0]         gap_cnt;
    logic [FRAME_W-1:0] frame_q;
    logic               frame_valid_q;
    logic               locked_q;

    logic       boundary;
    logic       is_sync;
    logic [3:0] sync_nxt;
    logic [7:0] gap_nxt;
    logic       unlock_evt;
    logic [7:0] unlock_count;
    logic [7:0] sync_err_count;

    assign boundary = (bus.shift_count_i == phase_q);
    assign is_sync  = (bus.data_i == SYNC_PATTERN);
    assign sync_nxt = sync_cnt + 4'd1;
    assign gap_nxt  = gap_cnt + 8'd1;

    // Gap expiry on a non-sync boundary while locked drops the lock.
    assign unlock_evt = (state == LOCKED) && boundary &&
                        !is_sync && (gap_nxt == MG);

    // Alignment FSM with registered frame, lock and phase outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            phase_q       <= 4'd0;
            sync_cnt      <= 4'd0;
            gap_cnt       <= 8'd0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (is_sync) begin
                        phase_q  <= bus.shift_count_i;
                        sync_cnt <= 4'd1;
                        gap_cnt  <= 8'd0;
                        state    <= ACQ_NEXT;
                        locked_q <= (ACQ_NEXT == LOCKED);
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (is_sync) begin
                            sync_cnt <= sync_nxt;
                            gap_cnt  <= 8'd0;
                            if (sync_nxt == LC) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            gap_cnt <= gap_nxt;
                            if (gap_nxt == MG) begin
                                state <= HUNT;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (is_sync) begin
                            gap_cnt <= 8'd0;
                        end else begin
                            frame_q       <= bus.data_i;
                            frame_valid_q <= 1'b1;
                            gap_cnt       <= gap_nxt;
                            if (gap_nxt == MG) begin
                                state    <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state    <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter8 u_unlock_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (unlock_evt),
        .count  (unlock_count)
    );

`ifdef CMD_FRAME_ALIGNER_SYNCERR_EN
    logic sync_err_evt;

    // Sync seen on the wrong bit phase while locked.
    assign sync_err_evt = (state == LOCKED) && !boundary && is_sync;

    sat_counter8 u_sync_err_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (sync_err_evt),
        .count  (sync_err_count)
    );
`else
    assign sync_err_count = 8'h00;
`endif

    assign bus.frame_o          = frame_q;
    assign bus.frame_valid_o    = frame_valid_q;
    assign bus.locked_o         = locked_q;
    assign bus.phase_o          = phase_q;
    assign bus.unlock_count_o   = unlock_count;
    assign bus.sync_err_count_o = sync_err_count;

endmodule

// File: tb/tb_cmd_frame_aligner.sv
// Directed bench for cmd_frame_aligner with a frame scoreboard.
// Stimulus pushes expected frames; a monitor pops them on each strobe.
`timescale 1ns/1ps
module tb_cmd_frame_aligner;
    import rd53b_cmd_pkg::*;

    localparam logic [15:0] SYNC = 16'h817E;
    localparam logic [15:0] FILL = 16'h0F0F;

    logic clk;
    logic reset;
    logic [3:0] sc;
    int n_vec;
    int n_err;
    logic [15:0] exp_q[$];

    cmd_frame_aligner_if bus ();

    cmd_frame_aligner #(
        .SYNC_PATTERN (SYNC),
        .LOCK_COUNT   (4),
        .MAX_GAP      (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.frame_valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame: got %0h expected no strobe",
                         bus.frame_o);
            end else begin
                chk("frame", {16'h0, bus.frame_o}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input logic [15:0] d);
        bus.data_i = d;
        bus.shift_count_i = sc;
        @(posedge clk);
        #1;
        sc = sc + 4'd1;
    endtask

    task automatic slot(input logic [3:0] ph, input logic [15:0] d);
        while (sc != ph) cyc(FILL);
        cyc(d);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_frame"}, {16'h0, bus.frame_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.frame_valid_o}, 32'h0);
        chk({tag, "_locked"}, {31'h0, bus.locked_o}, 32'h0);
        chk({tag, "_phase"}, {28'h0, bus.phase_o}, 32'h0);
        chk({tag, "_unlock"}, {24'h0, bus.unlock_count_o}, 32'h0);
        chk({tag, "_syncerr"}, {24'h0, bus.sync_err_count_o}, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sc = 4'd0;
        reset = 1'b1;
        bus.data_i = FILL;
        bus.shift_count_i = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Acquire lock at phase 7.
        for (int i = 0; i < 4; i++) begin
            chk("pre_lock", {31'h0, bus.locked_o}, 32'h0);
            slot(4'd7, SYNC);
        end
        chk("lock_rise", {31'h0, bus.locked_o}, 32'h1);
        chk("lock_phase", {28'h0, bus.phase_o}, 32'h7);
        exp_q.push_back(16'h1234);
        slot(4'd7, 16'h1234);

        // Sync frames are stripped from the output.
        slot(4'd7, SYNC);
        exp_q.push_back(16'hAAAA);
        slot(4'd7, 16'hAAAA);
        slot(4'd7, SYNC);
        exp_q.push_back(16'h5555);
        slot(4'd7, 16'h5555);

        // Gap race: sync lands on the boundary that would expire the gap.
        slot(4'd7, SYNC);
        for (int i = 0; i < 63; i++) begin
            exp_q.push_back(16'h1000 + 16'(i));
            slot(4'd7, 16'h1000 + 16'(i));
        end
        slot(4'd7, SYNC);
        chk("race_locked", {31'h0, bus.locked_o}, 32'h1);
        chk("race_unlock", {24'h0, bus.unlock_count_o}, 32'h0);

        // Loss of lock after 64 non-sync frames.
        for (int i = 0; i < 64; i++) begin
            chk("gap_locked", {31'h0, bus.locked_o}, 32'h1);
            exp_q.push_back(16'h2000 + 16'(i));
            slot(4'd7, 16'h2000 + 16'(i));
        end
        chk("unlock_fall", {31'h0, bus.locked_o}, 32'h0);
        chk("unlock_cnt", {24'h0, bus.unlock_count_o}, 32'h1);

        // VERIFY abort, then re-acquire at phase 3.
        slot(4'd5, SYNC);
        chk("verify_phase", {28'h0, bus.phase_o}, 32'h5);
        for (int i = 0; i < 64; i++) begin
            slot(4'd5, 16'h3000 + 16'(i));
            chk("verify_locked", {31'h0, bus.locked_o}, 32'h0);
        end
        slot(4'd3, SYNC);
        chk("rehunt_phase", {28'h0, bus.phase_o}, 32'h3);
        for (int i = 0; i < 3; i++) slot(4'd3, SYNC);
        chk("relock", {31'h0, bus.locked_o}, 32'h1);
        chk("relock_unlock", {24'h0, bus.unlock_count_o}, 32'h1);

        // Off-phase sync while locked.
        slot(4'd10, SYNC);
        chk("offsync_locked", {31'h0, bus.locked_o}, 32'h1);
        chk("offsync_phase", {28'h0, bus.phase_o}, 32'h3);
`ifdef CMD_FRAME_ALIGNER_SYNCERR_EN
        chk("syncerr_cnt", {24'h0, bus.sync_err_count_o}, 32'h1);
`else
        chk("syncerr_cnt", {24'h0, bus.sync_err_count_o}, 32'h0);
`endif

        // Reset mid-LOCKED with a frame on the boundary.
        while (sc != 4'd3) cyc(FILL);
        bus.data_i = 16'hBEEF;
        bus.shift_count_i = sc;
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        sc = sc + 4'd1;
        chk_zero("midreset_hold");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cyc(FILL);
        chk("post_reset_locked", {31'h0, bus.locked_o}, 32'h0);

        repeat (2) cyc(FILL);
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
